fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if -- instruction-memory and decode handshakes of the fetch unit.
//   Parameter size : address/PC width in bits.
//   IMEM group : IMEM_REQ/IMEM_ADDR (fetch -> memory), IMEM_GNT/IMEM_RVALID/IMEM_RDATA (memory -> fetch)
//   ID group   : ID_VALID/ID_INSTR/ID_PC (fetch -> decode), ID_READY (decode -> fetch)
//   master modport = fetch unit side, slave modport = memory/decode side.
interface fetch_unit_if #(
    parameter int size = 32
);
    logic            IMEM_REQ;
    logic [size-1:0] IMEM_ADDR;
    logic            IMEM_GNT;
    logic            IMEM_RVALID;
    logic [31:0]     IMEM_RDATA;
    logic            ID_VALID;
    logic            ID_READY;
    logic [31:0]     ID_INSTR;
    logic [size-1:0] ID_PC;

    modport master (
        output IMEM_REQ, IMEM_ADDR, ID_VALID, ID_INSTR, ID_PC,
        input  IMEM_GNT, IMEM_RVALID, IMEM_RDATA, ID_READY
    );
    modport slave (
        input  IMEM_REQ, IMEM_ADDR, ID_VALID, ID_INSTR, ID_PC,
        output IMEM_GNT, IMEM_RVALID, IMEM_RDATA, ID_READY
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch with in-order memory responses, a small
// instruction buffer and redirect/flush handling.
//   CLK, RESET       : clock, synchronous active-high reset
//   PC               : current PC register value
//   PC_next, PCWrite : PC register load value / active-low load enable
//   REDIRECT(_PC)    : taken branch/jump and its restart address
//   bus (master)     : IMEM request/response and decode handshakes
// DEPTH bounds buffered + in-flight instructions together, so a response can
// always be written without checking buffer space.
module fetch_unit #(
    parameter int size  = 32,
    parameter int DEPTH = 2
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [size-1:0] PC,
    output logic [size-1:0] PC_next,
    output logic            PCWrite,
    input  logic            REDIRECT,
    input  logic [size-1:0] REDIRECT_PC,
    fetch_unit_if.master    bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   outstanding, discard, occ, discard_redir;
    logic [size-1:0] iq [DEPTH];          // PCs of granted, unanswered fetches
    logic [PW-1:0]   iq_wr, iq_rd;
    logic [31:0]     buf_instr [DEPTH];
    logic [size-1:0] buf_pc [DEPTH];
    logic [PW-1:0]   buf_wr, buf_rd;
    logic            req, grant, resp_hit, drop_hit, push, pop, id_valid;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshake qualifiers. A response with nothing outstanding (e.g. one
    // belonging to a pre-reset grant) is never counted.
    always_comb begin
        req      = (state == RUN) && !RESET && !REDIRECT &&
                   (({1'b0, outstanding} + {1'b0, occ}) < (CW + 1)'(DEPTH));
        grant    = req && bus.IMEM_GNT;
        resp_hit = bus.IMEM_RVALID && (outstanding != '0);
        drop_hit = bus.IMEM_RVALID && (discard != '0);
        push     = (state == RUN) && resp_hit && !REDIRECT && !RESET;
        id_valid = !RESET && !REDIRECT && (occ != '0);
        pop      = id_valid && bus.ID_READY;
        // Fetches still owed by memory once a redirect hits; a response in
        // the redirect cycle itself is already accounted for.
        discard_redir = (state == FLUSH) ? discard - CW'(drop_hit)
                                         : outstanding - CW'(resp_hit);
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) state <= BOOT;
        else       state <= state_nx;
    end

    // Next state
    always_comb begin
        state_nx = state;
        if (REDIRECT) begin
            state_nx = (discard_redir != '0) ? FLUSH : RUN;
        end else begin
            case (state)
                BOOT:    state_nx = RUN;
                FLUSH:   if ((discard == '0) || (drop_hit && discard == CW'(1))) state_nx = RUN;
                default: state_nx = state;
            endcase
        end
    end

    // Outputs
    always_comb begin
        PCWrite       = 1'b1;
        PC_next       = PC;
        bus.IMEM_REQ  = req;
        bus.IMEM_ADDR = PC;
        bus.ID_VALID  = id_valid;
        bus.ID_INSTR  = buf_instr[buf_rd];
        bus.ID_PC     = buf_pc[buf_rd];
        if (!RESET) begin
            if (REDIRECT) begin
                PCWrite = 1'b0;
                PC_next = REDIRECT_PC & ~size'(3);   // word-align restart address
            end else if (grant) begin
                PCWrite = 1'b0;
                PC_next = PC + size'(4);
            end
        end
    end

    // Counters and queue pointers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            outstanding <= '0;
            discard     <= '0;
            occ         <= '0;
            iq_wr       <= '0;
            iq_rd       <= '0;
            buf_wr      <= '0;
            buf_rd      <= '0;
        end else if (REDIRECT) begin
            outstanding <= '0;
            discard     <= discard_redir;
            occ         <= '0;
            iq_wr       <= '0;
            iq_rd       <= '0;
            buf_wr      <= '0;
            buf_rd      <= '0;
        end else begin
            outstanding <= outstanding + CW'(grant) - CW'(push);
            occ         <= occ + CW'(push) - CW'(pop);
            if (grant) iq_wr <= inc(iq_wr);
            if (push) begin
                iq_rd  <= inc(iq_rd);
                buf_wr <= inc(buf_wr);
            end
            if (pop) buf_rd <= inc(buf_rd);
            if (state == FLUSH && drop_hit) discard <= discard - CW'(1);
        end
    end

    // Storage; grant/push are already suppressed under reset and redirect
    always_ff @(posedge CLK) begin
        if (grant) iq[iq_wr] <= PC;
        if (push) begin
            buf_instr[buf_wr] <= bus.IMEM_RDATA;
            buf_pc[buf_wr]    <= iq[iq_rd];
        end
    end
endmodule
